// File: rtl/otter_muldiv_pkg.sv
// Shared types and constants for the OTTER RV32M multiply/divide unit.
package otter_muldiv_pkg;

  // RV32M funct3 encodings handled by the unit
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } muldiv_state_t;

  localparam int          MULDIV_ITERS = 32;
  localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN      = 32'h8000_0000;

  // rs1 is read as two's complement for every signed op, including MULHSU
  function automatic logic op1_signed(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op2_signed(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div_op(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem_op(input muldiv_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/otter_muldiv_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/otter_muldiv.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps, fixed latency.
module otter_muldiv
  import otter_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Op1,
  input  logic [XLEN-1:0] Op2,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  muldiv_state_t     state_reg, state_next;
  muldiv_op_t        op_reg, op_next;
  logic [5:0]        cnt_reg, cnt_next;
  logic              neg_res_reg, neg_res_next;
  logic              div0_reg, div0_next;
  logic              ovf_reg, ovf_next;
  logic [XLEN-1:0]   op1_reg, op1_next;     // raw rs1, returned by REM on divide-by-zero
  logic [XLEN-1:0]   mcand_reg, mcand_next; // multiplicand or divisor magnitude
  logic [XLEN-1:0]   quo_reg, quo_next;     // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]   rem_reg, rem_next;
  logic [2*XLEN-1:0] prod_reg, prod_next;   // {accumulator, multiplier shifting out}
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [XLEN-1:0]   result_reg, result_next;

  muldiv_op_t        start_op;
  logic [1:0]        opnd_neg;
  logic [XLEN-1:0]   opnd_raw [2];
  logic [XLEN-1:0]   opnd_mag [2];

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     part_rem;  // 33-bit partial remainder for the current step
  logic              rem_ge;
  logic [XLEN-1:0]   rem_diff;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_raw, div_fix;
  logic [XLEN-1:0]   fin_result;

  assign start_op    = muldiv_op_t'(Funct3);
  assign opnd_raw[0] = Op1;
  assign opnd_raw[1] = Op2;
  assign opnd_neg[0] = op1_signed(start_op) & Op1[XLEN-1];
  assign opnd_neg[1] = op2_signed(start_op) & Op2[XLEN-1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd_mag
      muldiv_negate #(.W(XLEN)) u_opnd_neg (
        .neg  (opnd_neg[gi]),
        .din  (opnd_raw[gi]),
        .dout (opnd_mag[gi])
      );
    end
  endgenerate

  // One multiply step: add the multiplicand into the high half when the multiplier LSB is set
  assign mul_sum  = {1'b0, prod_reg[2*XLEN-1:XLEN]} + {1'b0, (prod_reg[0] ? mcand_reg : {XLEN{1'b0}})};

  // One restoring-divide step: bring down the next dividend bit and trial-subtract.
  // The remainder stays below the divisor, so the low XLEN bits of the difference are exact.
  assign part_rem = {rem_reg, quo_reg[XLEN-1]};
  assign rem_ge   = part_rem >= {1'b0, mcand_reg};
  assign rem_diff = part_rem[XLEN-1:0] - mcand_reg;

  assign div_raw  = is_rem_op(op_reg) ? rem_reg : quo_reg;

  muldiv_negate #(.W(2*XLEN)) u_prod_neg (
    .neg  (neg_res_reg),
    .din  (prod_reg),
    .dout (prod_fix)
  );

  muldiv_negate #(.W(XLEN)) u_div_neg (
    .neg  (neg_res_reg),
    .din  (div_raw),
    .dout (div_fix)
  );

  // Final result selection including the divide-by-zero and INT_MIN/-1 cases
  always_comb begin
    fin_result = prod_fix[XLEN-1:0];
    case (op_reg)
      OP_MUL:                        fin_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fin_result = div0_reg ? DIV0_QUOT :
                                                  ovf_reg  ? INT_MIN   : div_fix;
      OP_REM, OP_REMU:               fin_result = div0_reg ? op1_reg     :
                                                  ovf_reg  ? {XLEN{1'b0}} : div_fix;
      default:                       fin_result = prod_fix[XLEN-1:0];
    endcase
  end

  // Next-state, capture and iteration logic
  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    cnt_next     = cnt_reg;
    neg_res_next = neg_res_reg;
    div0_next    = div0_reg;
    ovf_next     = ovf_reg;
    op1_next     = op1_reg;
    mcand_next   = mcand_reg;
    quo_next     = quo_reg;
    rem_next     = rem_reg;
    prod_next    = prod_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    result_next  = result_reg;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          state_next   = CALC;
          op_next      = start_op;
          cnt_next     = '0;
          busy_next    = 1'b1;
          // Unsigned operands never set opnd_neg, so one expression covers all cases
          neg_res_next = (start_op == OP_REM) ? opnd_neg[0] : (opnd_neg[0] ^ opnd_neg[1]);
          div0_next    = (Op2 == {XLEN{1'b0}});
          ovf_next     = op2_signed(start_op) && (Op1 == INT_MIN) && (Op2 == {XLEN{1'b1}});
          op1_next     = Op1;
          mcand_next   = is_div_op(start_op) ? opnd_mag[1] : opnd_mag[0];
          quo_next     = opnd_mag[0];
          rem_next     = '0;
          prod_next    = {{XLEN{1'b0}}, opnd_mag[1]};
        end
      end
      CALC: begin
        if (cnt_reg == 6'(MULDIV_ITERS)) begin
          state_next  = FIN;
          done_next   = 1'b1;
          result_next = fin_result;
        end else begin
          cnt_next = cnt_reg + 6'd1;
          if (is_div_op(op_reg)) begin
            quo_next = {quo_reg[XLEN-2:0], rem_ge};
            rem_next = rem_ge ? rem_diff : part_rem[XLEN-1:0];
          end else begin
            prod_next = {mul_sum, prod_reg[XLEN-1:1]};
          end
        end
      end
      FIN: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_reg      <= OP_MUL;
      cnt_reg     <= '0;
      neg_res_reg <= 1'b0;
      div0_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      op1_reg     <= '0;
      mcand_reg   <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      prod_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
    end else begin
      op_reg      <= op_next;
      cnt_reg     <= cnt_next;
      neg_res_reg <= neg_res_next;
      div0_reg    <= div0_next;
      ovf_reg     <= ovf_next;
      op1_reg     <= op1_next;
      mcand_reg   <= mcand_next;
      quo_reg     <= quo_next;
      rem_reg     <= rem_next;
      prod_reg    <= prod_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      result_reg  <= result_next;
    end
  end

  assign Busy   = busy_reg;
  assign Done   = done_reg;
  assign Result = result_reg;

endmodule

// File: tb/tb_otter_muldiv.sv
// Self-checking bench for otter_muldiv: arithmetic reference model plus cycle-accurate timing model.
module tb_otter_muldiv;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] Op1 = 32'd0;
  logic [31:0] Op2 = 32'd0;
  logic        Busy, Done;
  logic [31:0] Result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  otter_muldiv #(.XLEN(32)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .Start  (Start),
    .Funct3 (Funct3),
    .Op1    (Op1),
    .Op2    (Op2),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV32M semantics computed with plain 64-bit / integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int si, sj;
    bit ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    si  = a;
    sj  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(si / sj);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(si % sj);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Timing model: k counts edges since the accepting edge; Done at k=33, idle again at k=34
  int          m_k = -1;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pending = 32'd0;

  initial begin
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        m_k = -1; m_busy = 1'b0; m_done = 1'b0; m_result = 32'd0;
      end else if (m_k < 0) begin
        if (Start) begin
          m_k = 0; m_busy = 1'b1; m_pending = ref_model(Funct3, Op1, Op2);
        end
      end else begin
        m_k++;
        if (m_k == 33) begin
          m_done = 1'b1; m_result = m_pending;
        end else if (m_k == 34) begin
          m_done = 1'b0; m_busy = 1'b0; m_k = -1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge CLK);
      check("busy",   {31'd0, Busy}, {31'd0, m_busy});
      check("done",   {31'd0, Done}, {31'd0, m_done});
      check("result", Result, m_result);
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'(0 - $urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  // Issue one op, optionally pulse Start mid-CALC (intr_at) or in the Done cycle (start_in_fin)
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit pin, input logic [31:0] lit, input int intr_at, input bit start_in_fin);
    int lat;
    lat = 0;
    @(posedge CLK); #2;
    Start = 1'b1; Funct3 = f; Op1 = a; Op2 = b;
    @(posedge CLK); #2;
    Start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK); #1;
      if (intr_at != 0 && n == intr_at) begin
        Start = 1'b1; Funct3 = 3'($urandom_range(0, 7)); Op1 = ~a; Op2 = b + 32'd1;
      end else if (intr_at != 0 && n == intr_at + 1) begin
        Start = 1'b0;
      end
      if (Done) begin
        lat = n;
        break;
      end
    end
    Start = 1'b0;
    check("latency", 32'(lat), 32'd33);
    if (pin) begin
      check("pin_model", ref_model(f, a, b), lit);
      check("pin_dut", Result, lit);
    end
    if (start_in_fin) begin
      Start = 1'b1; Funct3 = 3'd0; Op1 = 32'd3; Op2 = 32'd3;
      @(posedge CLK); #2;
      Start = 1'b0;
    end
    $display("op f=%0d a=%h b=%h -> %h latency=%0d", f, a, b, Result, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_done;
    #1 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check("reset_busy",   {31'd0, Busy}, 32'd0);
    check("reset_result", Result, 32'd0);
    #1 RST_N = 1'b1;

    // Directed vectors with hand-computed results
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 0, 0);
    do_op(3'd1, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFF, 0, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 0, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0);
    do_op(3'd4, 32'hFFFF_FFEC, 32'd3, 1, 32'hFFFF_FFFA, 0, 0);
    do_op(3'd6, 32'hFFFF_FFEC, 32'd3, 1, 32'hFFFF_FFFE, 0, 0);
    do_op(3'd5, 32'd100, 32'd7, 1, 32'd14, 0, 0);
    do_op(3'd7, 32'd100, 32'd7, 1, 32'd2, 0, 0);
    do_op(3'd5, 32'h1234_5678, 32'd0, 1, 32'hFFFF_FFFF, 0, 0);
    do_op(3'd6, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 0, 0);
    // Start during CALC is ignored; Start during the Done cycle is ignored
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 10, 1);
    do_op(3'd4, 32'hFFFF_FFEC, 32'd3, 1, 32'hFFFF_FFFA, 0, 0);

    // Reset in the middle of CALC
    @(posedge CLK); #2;
    Start = 1'b1; Funct3 = 3'd0; Op1 = 32'd9; Op2 = 32'd9;
    @(posedge CLK); #2;
    Start = 1'b0;
    repeat (15) @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    check("midrst_busy",   {31'd0, Busy}, 32'd0);
    check("midrst_done",   {31'd0, Done}, 32'd0);
    check("midrst_result", Result, 32'd0);
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (Done) saw_done = 1'b1;
    end
    check("no_done_after_rst", {31'd0, saw_done}, 32'd0);
    do_op(3'd0, 32'd5, 32'd5, 1, 32'd25, 0, 0);

    // Randomised ops, including corner operands and ignored Start pulses
    repeat (40) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int          intr;
      bit          fin;
      f    = 3'($urandom_range(0, 7));
      a    = pick();
      b    = pick();
      intr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
      fin  = ($urandom_range(0, 4) == 0);
      do_op(f, a, b, 0, 32'd0, intr, fin);
    end

    repeat (3) @(posedge CLK);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
